// File: rtl/bus_sched_rr.sv
// rtl/bus_sched_rr.sv - round-robin bus scheduler with tenure limit and lock; optional grant parking via ARB_PARK_EN
module bus_sched_rr #(
  parameter int NREQ       = 4,
  parameter int MAX_TENURE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_id,
  output logic            busy,
  output logic            preempt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  localparam logic [7:0] MAX_CNT = 8'(MAX_TENURE);

  state_e          state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic            busy_q, busy_d;
  logic            preempt_q, preempt_d;

  // Requests and locks widened to 8 so a 3-bit index always selects a real bit.
  logic [7:0]      req8, lock8;
  logic            win_found;
  logic [2:0]      win_idx;
  logic            others_req;
  logic [2:0]      owner_nxt;
  logic            park_on;

  assign req8       = 8'(req);
  assign lock8      = 8'(lock);
  assign others_req = |(req8 & ~(8'd1 << owner_q));
  assign owner_nxt  = (owner_q == 3'(NREQ-1)) ? 3'd0 : owner_q + 3'd1;

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] idx);
    return NREQ'(8'd1 << idx);
  endfunction

`ifdef ARB_PARK_EN
  logic park_vld_q, park_vld_d;

  assign park_vld_d = park_vld_q | (state_d == S_GRANT);
  assign park_on    = park_vld_q;

  // Parking becomes valid once the bus has had a first owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      park_vld_q <= 1'b0;
    end else begin
      park_vld_q <= park_vld_d;
    end
  end
`else
  assign park_on = 1'b0;
`endif

  // Winner: first requester at or after ptr, wrapping at NREQ.
  always_comb begin
    logic [3:0] pos;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr_q} + 4'(i);
      if (pos >= 4'(NREQ)) pos = pos - 4'(NREQ);
      if (!win_found && req8[pos[2:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[2:0];
      end
    end
  end

  // Next state, owner, pointer, tenure and the outputs registered from them.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (park_on && req8[owner_q]) begin
          // Parked owner takes the bus back without a dead cycle.
          state_d = S_GRANT;
          cnt_d   = 8'd1;
        end else if (win_found) begin
          if (park_on) begin
            state_d = S_CLEAR;
          end else begin
            state_d = S_GRANT;
            owner_d = win_idx;
            cnt_d   = 8'd1;
          end
        end
      end
      S_GRANT: begin
        if (!req8[owner_q]) begin
          // Release wins over preemption in the same cycle.
          state_d = S_CLEAR;
          ptr_d   = owner_nxt;
        end else if (cnt_q == MAX_CNT && others_req && !lock8[owner_q]) begin
          state_d   = S_CLEAR;
          ptr_d     = owner_nxt;
          preempt_d = 1'b1;
        end else if (cnt_q != MAX_CNT) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CLEAR: begin
        if (win_found) begin
          state_d = S_GRANT;
          owner_d = win_idx;
          cnt_d   = 8'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d == S_GRANT);
    grant_d    = '0;
    grant_id_d = '0;
    if (state_d == S_GRANT || (state_d == S_IDLE && park_on)) begin
      grant_d    = onehot(owner_d);
      grant_id_d = owner_d;
    end
  end

  // State, owner, pointer, tenure counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_sched_rr.sv
// tb/tb_bus_sched_rr.sv - bench for bus_sched_rr
module tb_bus_sched_rr;

  localparam int N    = 4;
  localparam int MAXT = 4;
  localparam int IW   = $clog2(N);

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [N-1:0] grant;
  logic [2:0]   grant_id;
  logic         busy;
  logic         preempt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: current owner (-1 when none), tenure so far, pointer,
  // whether this cycle is the dead turnaround, and whether it follows a revocation.
  int m_owner;
  int m_tenure;
  int m_ptr;
  bit m_clear;
  bit m_preempt;

  logic [N-1:0] r_rand;
  logic [N-1:0] l_rand;

  bus_sched_rr #(.NREQ(N), .MAX_TENURE(MAXT)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .lock     (lock),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .preempt  (preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (r[IW'(idx)]) return idx;
    end
    return -1;
  endfunction

  function automatic int exp_grant();
    return (m_owner >= 0) ? (1 << m_owner) : 0;
  endfunction

  function automatic int exp_id();
    return (m_owner >= 0) ? m_owner : 0;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_tenure  = 0;
    m_ptr     = 0;
    m_clear   = 1'b0;
    m_preempt = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] l);
    logic [N-1:0] own;
    own       = '0;
    if (m_owner >= 0) own[IW'(m_owner)] = 1'b1;
    m_preempt = 1'b0;
    if (m_clear || m_owner < 0) begin
      m_clear  = 1'b0;
      m_owner  = pick(r, m_ptr);
      m_tenure = 1;
    end else if (!r[IW'(m_owner)]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_clear = 1'b1;
    end else if (m_tenure >= MAXT && (r & ~own) != 0 && !l[IW'(m_owner)]) begin
      m_ptr     = (m_owner + 1) % N;
      m_owner   = -1;
      m_clear   = 1'b1;
      m_preempt = 1'b1;
    end else if (m_tenure < MAXT) begin
      m_tenure++;
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", int'(grant), exp_grant());
      check("grant_id", int'(grant_id), exp_id());
      check("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
      check("preempt", int'(preempt), int'(m_preempt));
    end
  end

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l);
    req  = r;
    lock = l;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(r, l);
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int g, input int id, input int b, input int p);
    check({tag, ".grant"}, int'(grant), g);
    check({tag, ".grant_id"}, int'(grant_id), id);
    check({tag, ".busy"}, int'(busy), b);
    check({tag, ".preempt"}, int'(preempt), p);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    step('0, '0);
    reset = 1'b0;
  endtask

  // Assert reset between edges and confirm outputs drop without a clock.
  task automatic mid_reset(input int cycles);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    expect_out("async_rst", 0, 0, 0, 0);
    repeat (cycles) step(req, lock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Single requester, release, dead cycle, idle
    step(4'b0001, '0); expect_out("t1_grant", 1, 0, 1, 0);
    step(4'b0000, '0); expect_out("t1_clear", 0, 0, 0, 0);
    step(4'b0000, '0); expect_out("t1_idle", 0, 0, 0, 0);

    // Two simultaneous requesters from ptr 0
    do_reset();
    step(4'b0101, '0); expect_out("t2_first", 1, 0, 1, 0);
    step(4'b0100, '0); expect_out("t2_clear", 0, 0, 0, 0);
    step(4'b0100, '0); expect_out("t2_second", 4, 2, 1, 0);

    // Pointer wraps past index 3 after owner 2 releases
    step(4'b0000, '0); expect_out("t5_clear", 0, 0, 0, 0);
    step(4'b0011, '0); expect_out("t5_wrap", 1, 0, 1, 0);
    step(4'b0000, '0);
    step(4'b0000, '0);

    // Tenure preemption
    do_reset();
    step(4'b0010, '0); expect_out("t3_g1", 2, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, '0); expect_out("t3_hold", 2, 1, 1, 0);
    end
    step(4'b1010, '0); expect_out("t3_preempt", 0, 0, 0, 1);
    step(4'b1010, '0); expect_out("t3_next", 8, 3, 1, 0);
    step(4'b0000, '0);
    step(4'b0000, '0);

    // Lock holds the grant; dropping it lets preemption happen
    do_reset();
    step(4'b0010, 4'b0010); expect_out("t4_g1", 2, 1, 1, 0);
    for (int i = 0; i < 22; i++) begin
      step(4'b1010, 4'b0010); expect_out("t4_locked", 2, 1, 1, 0);
    end
    step(4'b1010, 4'b0000); expect_out("t4_preempt", 0, 0, 0, 1);
    step(4'b1010, 4'b0000); expect_out("t4_next", 8, 3, 1, 0);
    step(4'b0000, '0);
    step(4'b0000, '0);

    // Asynchronous reset mid-grant, then pointer back at 0
    do_reset();
    step(4'b0100, '0); expect_out("t6_grant", 4, 2, 1, 0);
    step(4'b0100, '0);
    mid_reset(2);
    step(4'b1010, '0); expect_out("t6_after", 2, 1, 1, 0);
    step(4'b0000, '0);
    step(4'b0000, '0);

    // Randomized traffic against the model
    r_rand = '0;
    l_rand = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) r_rand[IW'(b)] = ~r_rand[IW'(b)];
      end
      if ($urandom_range(0, 15) == 0) begin
        l_rand = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      end
      step(r_rand, l_rand);
      if ($urandom_range(0, 199) == 0) mid_reset(1 + int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_sched_rr.md
Name: bus_sched_rr

Overview:
Round-robin scheduler for the shared system bus. Supports up to 8 bus masters: TDSP, DMA and future peripherals.
- Grants are registered and one-hot.
- A one-cycle dead turnaround separates owners.
- A tenure limit stops a single master from starving the others.
- The lock input exempts an owner from tenure preemption for atomic sequences.

Parameters:
NREQ, 4, number of requesters; legal range 2..8.
MAX_TENURE, 16, maximum grant cycles while another request is pending; legal range 1..255.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  system reset; asynchronous, active-high.
req  in  NREQ  per-master bus request, level-sensitive.
lock  in  NREQ  per-master lock; only the current owner's bit is examined.
grant  out  NREQ  registered one-hot grant; all zeros when no owner.
grant_id  out  3  index of the current owner; 0 when grant is all zeros.
busy  out  1  high while in state GRANT.
preempt  out  1  one-cycle pulse on the first CLEAR cycle after a tenure revocation.

Behaviour:
- Reset values: grant=0, grant_id=0, busy=0, preempt=0, state=IDLE, ptr=0, cnt=0.
- Reset is asynchronous and may be asserted at any time, including mid-grant. All outputs clear immediately; no CLEAR cycle follows.
- State register: IDLE, GRANT, CLEAR. The outputs are registered from the next-state and next-owner logic.
- Latency: a req sampled at edge n produces grant high after edge n; one clock from request to grant.
- Winner selection: lowest index ≥ ptr with req set, wrapping NREQ-1 → 0. ptr resets to 0.
- IDLE:
  - any req → GRANT to the winner, cnt=1;
  - else remain in IDLE.
- GRANT:
  - req[owner]=0 → CLEAR. This is a normal release and has priority over preemption in the same cycle.
  - cnt==MAX_TENURE, any other req set, and lock[owner]=0 → CLEAR, with preempt=1 during that CLEAR cycle.
  - Otherwise stay in GRANT; cnt increments and saturates at MAX_TENURE.
- CLEAR:
  - grant=0 for exactly one cycle; ptr ← (owner+1) mod NREQ.
  - Next state: any req → GRANT to the winner searched from the new ptr, cnt=1; else IDLE.
- A non-owner that drops req before being granted is simply not considered; no memory of past requests.
- lock bits of non-owners are ignored. lock[owner]=1 with req[owner]=1 holds the grant indefinitely.
- MAX_TENURE=1: an owner is preempted after one grant cycle if contended and unlocked.
- grant_id and busy are always consistent with grant in the same cycle.
- Requester indices ≥ NREQ do not exist. ptr wrap uses NREQ, not 8.

Optional Feature:
Macro: ARB_PARK_EN.

Defined:
- In IDLE the grant stays parked on the last owner; grant_id follows, busy=0.
- Parked owner requests → GRANT with no dead cycle, cnt=1.
- A different master requests → one CLEAR cycle (grant=0), then grant to the winner.
- After reset nothing is parked (grant=0) until the first ownership.

Undefined:
- IDLE always drives grant=0.

Test Plan:
1. Release reset; req=0001 → grant=0001 one clock later, grant_id=0, busy=1. Drop req → grant=0000 one cycle (CLEAR), then IDLE.
2. ptr=0; req=0101 simultaneously → grant=0001. req[0] drops → one cycle grant=0000 → grant=0100, grant_id=2.
3. MAX_TENURE=4; req[1] held, then req[3] raised → grant=0010 for exactly 4 cycles, then preempt=1 with grant=0000 for one cycle, then grant=1000.
4. As 3 with lock[1]=1 → grant=0010 held for 20+ cycles, preempt never asserts. Drop lock[1] → preempt follows on the next edge.
5. After owner 2 releases (ptr=3), req=0011 → grant=0001 (wrap past index 3).
6. reset asserted mid-GRANT between clock edges → grant, busy and grant_id clear immediately. After release, req=1010 → grant=0010 (ptr back at 0).
